// File: rtl/if_id_pipe_pkg.sv
// if_id_pipe_pkg: shared widths, PC step, default bubble encoding and stage state type.
package if_id_pipe_pkg;
  localparam int PC_W = 16;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 16'd4;
  localparam logic [INSTR_W-1:0] NOP_DEFAULT = 32'h0000_0000;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/if_id_pipe_sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones; clear has priority over inc.
module sat_counter16 (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk_i)
    if (clear_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline register with flush > stall > capture priority.
// Define IF_ID_PERF_EN to add saturating stall/flush event counters.
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               DHZ_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
`ifdef IF_ID_PERF_EN
  output logic [15:0]        stall_cnt_o,
  output logic [15:0]        flush_cnt_o,
`endif
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus4_o,
  output logic [INSTR_W-1:0] instr_o
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc4_q, pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pc4_d = pc4_q;
    instr_d = instr_q;
    if (flush_i) begin
      state_d = EMPTY;
      pc_d = '0;
      pc4_d = '0;
      instr_d = NOP_INSTR;
    end else if (!DHZ_i) begin
      state_d = FULL;
      pc_d = pc_i;
      pc4_d = pc_i + PC_STEP;
      instr_d = instr_i;
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= EMPTY;
      pc_q <= '0;
      pc4_q <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pc4_q <= pc4_d;
      instr_q <= instr_d;
    end
  assign valid_o = (state_q == FULL);
  assign pc_o = pc_q;
  assign pc_plus4_o = pc4_q;
  assign instr_o = instr_q;
`ifdef IF_ID_PERF_EN
  sat_counter16 u_stall_cnt (.clk_i(clk_i), .clear_i(rst_i), .inc_i(DHZ_i && !flush_i), .cnt_o(stall_cnt_o));
  sat_counter16 u_flush_cnt (.clk_i(clk_i), .clear_i(rst_i), .inc_i(flush_i), .cnt_o(flush_cnt_o));
`endif
endmodule
